// File: rtl/wash_sequencer.sv
// wash_sequencer: steps the selected wash program through its fill, wash,
// drain, rinse and spin phases on the 1 Hz clk_s domain. It drives the inlet
// valve, drain valve and motor, exports the remaining time, and raises a
// finish level for the power-off block.
//
// Ports:
//   clk_s        1 Hz second clock
//   reset        asynchronous, active-high
//   power_on     machine powered; low forces a return to IDLE
//   start_pause  1-cycle pulse: start / pause / resume / acknowledge
//   mode_btn     1-cycle pulse: cycle program while IDLE
//   mode         selected program (0 full, 1 wash, 2 rinse+spin, 3 spin)
//   phase        current state code
//   phase_left   seconds left in current phase
//   total_left   seconds left in program
//   running      active phase, not paused
//   paused       active phase, paused
//   water_in     inlet valve
//   drain        drain valve
//   motor_on     motor enable
//   motor_dir    motor direction (0 forward, 1 reverse)
//   finish       program complete, held through DONE
//
// state   | meaning
// IDLE    | waiting for start, mode selectable
// FILL_W  | fill for wash
// WASH    | wash agitation
// DRAIN_W | drain wash water
// FILL_R  | fill for rinse
// RINSE   | rinse agitation
// DRAIN_R | drain rinse water
// SPIN    | spin with drain open
// DONE    | program complete, finish held
module wash_sequencer #(
  parameter int unsigned FILL_S  = 2,
  parameter int unsigned WASH_S  = 6,
  parameter int unsigned DRAIN_S = 2,
  parameter int unsigned RINSE_S = 6,
  parameter int unsigned SPIN_S  = 3
) (
  input  logic       clk_s,
  input  logic       reset,
  input  logic       power_on,
  input  logic       start_pause,
  input  logic       mode_btn,
  output logic [1:0] mode,
  output logic [3:0] phase,
  output logic [3:0] phase_left,
  output logic [7:0] total_left,
  output logic       running,
  output logic       paused,
  output logic       water_in,
  output logic       drain,
  output logic       motor_on,
  output logic       motor_dir,
  output logic       finish
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL_W  = 4'd1,
    WASH    = 4'd2,
    DRAIN_W = 4'd3,
    FILL_R  = 4'd4,
    RINSE   = 4'd5,
    DRAIN_R = 4'd6,
    SPIN    = 4'd7,
    DONE    = 4'd8
  } state_t;

  localparam logic [7:0] TOTAL_SPIN  = 8'(SPIN_S);
  localparam logic [7:0] TOTAL_RINSE = 8'(FILL_S + RINSE_S + DRAIN_S + SPIN_S);
  localparam logic [7:0] TOTAL_WASH  = 8'(FILL_S + WASH_S + DRAIN_S);
  localparam logic [7:0] TOTAL_FULL  = 8'(FILL_S + WASH_S + DRAIN_S + FILL_S
                                          + RINSE_S + DRAIN_S + SPIN_S);

  state_t     state, state_n, target;
  logic [1:0] mode_q, mode_n;
  logic [3:0] pl_q, pl_n;
  logic [7:0] tl_q, tl_n;
  logic       paused_q, paused_n;

  function automatic logic [3:0] dur(input state_t s);
    case (s)
      FILL_W, FILL_R:   dur = 4'(FILL_S);
      WASH:             dur = 4'(WASH_S);
      DRAIN_W, DRAIN_R: dur = 4'(DRAIN_S);
      RINSE:            dur = 4'(RINSE_S);
      SPIN:             dur = 4'(SPIN_S);
      default:          dur = 4'd0;
    endcase
  endfunction

  function automatic state_t first_of(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: first_of = FILL_W;
      2'd2:       first_of = FILL_R;
      default:    first_of = SPIN;
    endcase
  endfunction

  function automatic logic [7:0] total_of(input logic [1:0] m);
    case (m)
      2'd0:    total_of = TOTAL_FULL;
      2'd1:    total_of = TOTAL_WASH;
      2'd2:    total_of = TOTAL_RINSE;
      default: total_of = TOTAL_SPIN;
    endcase
  endfunction

  // Wash-only program skips the rinse half after the first drain.
  function automatic state_t succ(input state_t s, input logic [1:0] m);
    case (s)
      FILL_W:  succ = WASH;
      WASH:    succ = DRAIN_W;
      DRAIN_W: succ = (m == 2'd1) ? DONE : FILL_R;
      FILL_R:  succ = RINSE;
      RINSE:   succ = DRAIN_R;
      DRAIN_R: succ = SPIN;
      default: succ = DONE;
    endcase
  endfunction

  always_ff @(posedge clk_s or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 2'd0;
      pl_q     <= 4'd0;
      tl_q     <= 8'd0;
      paused_q <= 1'b0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      pl_q     <= pl_n;
      tl_q     <= tl_n;
      paused_q <= paused_n;
    end
  end

  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    pl_n     = pl_q;
    tl_n     = tl_q;
    paused_n = paused_q;
    target   = IDLE;
    if (!power_on) begin
      state_n  = IDLE;
      mode_n   = 2'd0;
      pl_n     = 4'd0;
      tl_n     = 8'd0;
      paused_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pause) begin
            target   = first_of(mode_q);
            state_n  = target;
            pl_n     = dur(target);
            tl_n     = total_of(mode_q);
            paused_n = 1'b0;
          end else if (mode_btn) begin
            mode_n = 2'(mode_q + 2'd1);
          end
        end
        DONE: begin
          pl_n = 4'd0;
          tl_n = 8'd0;
          if (start_pause) state_n = IDLE;
        end
        default: begin
          // A pause pulse still lets this edge's decrement/transition happen;
          // a resume pulse only unfreezes, counting restarts next edge.
          if (start_pause) paused_n = !paused_q;
          if (!paused_q) begin
            tl_n = tl_q - 8'd1;
            if (pl_q == 4'd1) begin
              target  = succ(state, mode_q);
              state_n = target;
              pl_n    = dur(target);
            end else begin
              pl_n = pl_q - 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    water_in  = 1'b0;
    drain     = 1'b0;
    motor_on  = 1'b0;
    motor_dir = 1'b0;
    running   = (state != IDLE) && (state != DONE) && !paused_q;
    if (running) begin
      case (state)
        FILL_W, FILL_R:   water_in = 1'b1;
        DRAIN_W, DRAIN_R: drain = 1'b1;
        WASH, RINSE: begin
          motor_on  = 1'b1;
          motor_dir = pl_q[1];
        end
        SPIN: begin
          motor_on = 1'b1;
          drain    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mode       = mode_q;
  assign phase      = state;
  assign phase_left = pl_q;
  assign total_left = tl_q;
  assign paused     = paused_q;
  assign finish     = (state == DONE);

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing-machine controller. Runs on the 1 Hz `clk_s` domain. Steps the selected wash program through fill, wash, drain, rinse and spin phases, and drives the water valve, drain valve and motor. Exports remaining time for the display and a `finish` level that the power-off block consumes to start its auto-shutdown countdown.

## Interface
- `FILL_S`, default 2: fill phase duration in seconds, range 1..15.
- `WASH_S`, default 6: wash phase duration in seconds, range 1..15.
- `DRAIN_S`, default 2: drain phase duration in seconds, range 1..15.
- `RINSE_S`, default 6: rinse phase duration in seconds, range 1..15.
- `SPIN_S`, default 3: spin phase duration in seconds, range 1..15.
- `clk_s`  in  1  1 Hz system second clock.
- `reset`  in  1  Asynchronous, active-high.
- `power_on`  in  1  Machine powered, from the power-off block's LED output. Low forces a synchronous return to IDLE.
- `start_pause`  in  1  One-cycle pulse, synchronous to `clk_s`. Starts, pauses, resumes or acknowledges.
- `mode_btn`  in  1  One-cycle pulse. Cycles the program while in IDLE.
- `mode`  out  2  Selected program: 0 full, 1 wash-only, 2 rinse+spin, 3 spin-only.
- `phase`  out  4  Current state code, as listed in Operation.
- `phase_left`  out  4  Seconds remaining in the current phase.
- `total_left`  out  8  Seconds remaining in the program.
- `running`  out  1  In an active phase and not paused.
- `paused`  out  1  In an active phase and paused.
- `water_in`  out  1  Inlet valve.
- `drain`  out  1  Drain valve.
- `motor_on`  out  1  Motor enable.
- `motor_dir`  out  1  Motor direction: 0 forward, 1 reverse.
- `finish`  out  1  Program complete. Level, held for the whole DONE state.

## Operation
- States and codes:
  - IDLE=0, FILL_W=1, WASH=2, DRAIN_W=3, FILL_R=4, RINSE=5, DRAIN_R=6, SPIN=7, DONE=8.
  - `phase` outputs the state code directly.
- Sequences by mode:
  - 0: FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DONE.
  - 1: FILL_W, WASH, DRAIN_W, DONE.
  - 2: FILL_R, RINSE, DRAIN_R, SPIN, DONE.
  - 3: SPIN, DONE.
- IDLE:
  - `mode_btn` increments `mode`, wrapping 3 to 0.
  - `start_pause` with `power_on`=1 enters the mode's first phase. It loads `phase_left` with that phase's duration and `total_left` with the sum of the mode's durations (mode 0 default is 23).
  - When `start_pause` and `mode_btn` arrive in the same cycle, the start wins with the current mode and `mode_btn` is dropped.
- Active phases, not paused:
  - Each edge decrements `phase_left` and `total_left`.
  - On an edge where `phase_left`==1, move to the next state and load the next duration.
  - Each phase therefore lasts exactly its duration in running cycles.
- Pause:
  - `start_pause` in an active phase toggles `paused`.
  - While paused, both counters freeze and all actuator outputs are 0.
  - `mode_btn` is ignored outside IDLE.
- DONE:
  - `finish`=1, counters are 0, actuators are 0.
  - `start_pause` returns to IDLE and clears `finish`. `mode` is kept.
- Actuators, all gated by not-paused:
  - FILL_W and FILL_R: `water_in`=1.
  - DRAIN_W and DRAIN_R: `drain`=1.
  - WASH and RINSE: `motor_on`=1, `motor_dir`=`phase_left[1]`.
  - SPIN: `motor_on`=1, `drain`=1, `motor_dir`=0.
- `power_on`=0 in any state:
  - Next edge goes to IDLE, clears `paused` and the counters, and sets `mode`=0.
  - This takes priority over every button.

## Timing
- All outputs are registered, or decoded from registered state and `paused` only.
- Reset values:
  - State IDLE.
  - `mode`, `phase_left`, `total_left` = 0.
  - All 1-bit outputs 0.
- Reset is asynchronous. Asserting it mid-program aborts immediately to the reset values.
- Latency:
  - A start sampled at edge k makes the first phase visible after edge k.
  - `finish` rises after edge k+T plus the number of paused cycles.
- A pause pulse at edge p freezes the counters at their post-edge-p values. A resume pulse at edge r resumes decrementing from edge r+1.
- A `start_pause` on the same edge as a phase transition toggles pause and freezes the counters; the transition still takes effect on that edge.
- `total_left` never underflows; it is 0 exactly when the state is DONE or IDLE.

## Test plan
- Reset, then mode_btn ×5 -> `mode` reads 1 (wraps via 3 to 0); all actuators 0; `phase`=0.
- Mode 3, start at edge 0 -> SPIN with `phase_left` 3,2,1, `motor_on`=`drain`=1; `finish`=1 after edge 3; start_pause -> IDLE, `finish`=0.
- Mode 0, start, run to completion -> phase codes 1,2,3,4,5,6,7,8 with dwell 2,6,2,2,6,2,3; `total_left` 23 down to 0; `finish` after 23 edges; `motor_dir` toggles every 2 s in WASH.
- Mode 1, pause at WASH `phase_left`=4, hold 5 cycles, resume -> counters hold, actuators 0, `paused`=1; `finish` delayed by exactly 5 cycles (after edge 15 instead of 10).
- `power_on` dropped during RINSE -> next edge IDLE, `mode`=0, counters 0; async `reset` mid-FILL_W -> all outputs 0 without waiting for a clock edge.
- Simultaneous `start_pause` and `mode_btn` in IDLE with mode 2 -> FILL_R entered, `mode` stays 2, `total_left`=13.
